window_3x3_linebuf: RTL



---
 rtl/window_3x3_linebuf_pkg.sv | 11 +
 rtl/window_3x3_linebuf_if.sv | 29 ++
 rtl/window_3x3_linebuf_line_buffer.sv | 22 ++
 rtl/window_3x3_linebuf.sv | 98 +++++++++
 4 files changed

// File: rtl/window_3x3_linebuf_pkg.sv
// Shared definitions for the 3x3 raster-to-window stage and the kernel that consumes it.
package window_3x3_linebuf_pkg;
  localparam int DATA_W_DEF = 13;
  localparam int IMG_W_DEF  = 64;
  localparam int IMG_H_DEF  = 64;
  localparam int WIN_N      = 9;

  typedef logic [DATA_W_DEF-1:0] pixel_t;
  // p0..p8, index 0 = top-left, 8 = bottom-right
  typedef pixel_t [WIN_N-1:0] window_t;
endpackage

// File: rtl/window_3x3_linebuf_if.sv
// Pixel-in / window-out bundle. master = pixel source side, slave = window stage.
interface window_3x3_linebuf_if #(
  parameter int DATA_W = 13,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int CW     = $clog2(IMG_W),
  parameter int RW     = $clog2(IMG_H)
);
  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] in_pixel;
  logic              out_valid;
  logic              out_last;
  logic [RW-1:0]     out_row;
  logic [CW-1:0]     out_col;
  logic [DATA_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  out_valid, out_last, out_row, out_col,
    input  p0, p1, p2, p3, p4, p5, p6, p7, p8
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output out_valid, out_last, out_row, out_col,
    output p0, p1, p2, p3, p4, p5, p6, p7, p8
  );
endinterface

// File: rtl/window_3x3_linebuf_line_buffer.sv
// One image row of storage; combinational read of the old word, write on the same edge.
module window_3x3_linebuf_line_buffer #(
  parameter int DATA_W = 13,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  // Not reset: stale words are never exposed because windows need c>=2 and r>=2.
  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Write the new word; the read above still sees the previous contents this cycle.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/window_3x3_linebuf.sv
// Raster-to-3x3-window stage: two line buffers plus a 3x3 shift window, 1-cycle latency.
module window_3x3_linebuf
  import window_3x3_linebuf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int CW     = $clog2(IMG_W),
  parameter int RW     = $clog2(IMG_H)
) (
  input  logic clk,
  input  logic rst_n,
  window_3x3_linebuf_if.slave bus
);
  logic                          accept;
  logic [CW-1:0]                 col, cur_c;
  logic [RW-1:0]                 row, cur_r;
  logic                          end_c, end_r, win_ok;
  logic [DATA_W-1:0]             top_rd, mid_rd;
  logic [WIN_N-1:0][DATA_W-1:0]  win;
  logic                          out_valid_q, out_last_q;
  logic [RW-1:0]                 out_row_q;
  logic [CW-1:0]                 out_col_q;

  // in_sof forces the pixel to (0,0) regardless of where the counters are
  assign accept = bus.in_valid;
  assign cur_c  = bus.in_sof ? '0 : col;
  assign cur_r  = bus.in_sof ? '0 : row;
  assign end_c  = (cur_c == CW'(IMG_W-1));
  assign end_r  = (cur_r == RW'(IMG_H-1));
  assign win_ok = (cur_r >= RW'(2)) && (cur_c >= CW'(2));

  // lb_top holds row r-2, lb_mid holds row r-1 at the current column
  window_3x3_linebuf_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_lb_top (
    .clk(clk), .we(accept), .addr(cur_c), .wdata(mid_rd), .rdata(top_rd)
  );
  window_3x3_linebuf_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_lb_mid (
    .clk(clk), .we(accept), .addr(cur_c), .wdata(bus.in_pixel), .rdata(mid_rd)
  );

  // Raster position counters, advanced from the (possibly sof-forced) current position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (end_c) begin
        col <= '0;
        row <= end_r ? '0 : cur_r + RW'(1);
      end else begin
        col <= cur_c + CW'(1);
        row <= cur_r;
      end
    end
  end

  // Shift the 3x3 window left by one column on each accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (accept) begin
      win[0] <= win[1]; win[1] <= win[2]; win[2] <= top_rd;
      win[3] <= win[4]; win[4] <= win[5]; win[5] <= mid_rd;
      win[6] <= win[7]; win[7] <= win[8]; win[8] <= bus.in_pixel;
    end
  end

  // Valid/last pulses and the window centre; centre only moves on real windows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      out_valid_q <= accept && win_ok;
      out_last_q  <= accept && end_r && end_c;
      if (accept && win_ok) begin
        out_row_q <= cur_r - RW'(1);
        out_col_q <= cur_c - CW'(1);
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;
  assign bus.p0 = win[0];
  assign bus.p1 = win[1];
  assign bus.p2 = win[2];
  assign bus.p3 = win[3];
  assign bus.p4 = win[4];
  assign bus.p5 = win[5];
  assign bus.p6 = win[6];
  assign bus.p7 = win[7];
  assign bus.p8 = win[8];
endmodule
